// File: rtl/div_seq_pkg.sv
// div_seq_pkg -- shared definitions for the sequential divider.
//
// Contents:
//   div_state_e   : FSM state encodings (DIV_IDLE .. DIV_DONE)
//   DIV_ITER_NUM  : number of restoring shift-subtract steps (one per bit)
//   DIV_CNT_W     : width of the iteration counter
//   abs32()       : conditional two's-complement negation helper
package div_seq_pkg;

  localparam int DIV_ITER_NUM = 32;
  localparam int DIV_CNT_W    = 5;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  // Negate v when neg is set. Used both for taking magnitudes and for the
  // final sign correction; 0x80000000 maps onto itself, which is exactly the
  // wrap behaviour wanted for 0x80000000 / -1.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring shift-subtract step of an unsigned 32-bit divide.
//
// The partial remainder and the dividend/quotient word are treated as one
// 64-bit shift register {rem, quo}. Each step shifts it left by one; if the
// shifted remainder is at least the divisor it is reduced and a 1 enters the
// quotient, otherwise a 0 enters.
//
// Ports:
//   rem_in   in  32  partial remainder before this step
//   quo_in   in  32  dividend bits not yet consumed / quotient bits so far
//   divisor  in  32  divisor magnitude
//   rem_out  out 32  partial remainder after this step
//   quo_out  out 32  shifted quotient word with the new quotient bit in bit 0
import div_seq_pkg::*;

module div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  // 33 bits: the shifted remainder can exceed 32 bits before subtraction.
  logic [32:0] shifted;
  logic        fits;

  assign shifted = {rem_in, quo_in[31]};
  assign fits    = (shifted >= {1'b0, divisor});

  always_comb begin
    rem_out = shifted[31:0];
    quo_out = {quo_in[30:0], 1'b0};
    if (fits) begin
      // Result is below the divisor, so the low 32 bits of the difference
      // are exact. A zero divisor always "fits", giving quotient all-ones
      // and remainder equal to the dividend.
      rem_out = shifted[31:0] - divisor;
      quo_out = {quo_in[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq -- multi-cycle 32-bit divider for the EXE stage (DIV / DIVU).
//
// Sequence after acceptance: PREP (take magnitudes, 1 cycle), ITER (32
// restoring steps), FIX (sign correction, results registered), DONE (1-cycle
// result strobe, stall released so EXE advances). The pipeline stall is held
// from the request cycle through FIX.
//
// Configuration macro DIV_UNSIGNED_EN: when defined, div_signed_i selects
// signed/unsigned; when undefined, every operation is signed.
//
// Ports:
//   cpu_clk_50M     in  1   clock, rising edge
//   cpu_rst_n       in  1   asynchronous active-low reset
//   div_start_i     in  1   current EXE instruction is a divide (held in stall)
//   div_signed_i    in  1   1 = signed divide
//   div_src1_i      in  32  dividend
//   div_src2_i      in  32  divisor
//   div_annul_i     in  1   flush; abandons the operation in progress
//   stallreq_div_o  out 1   stall request
//   div_busy_o      out 1   FSM not idle
//   div_done_o      out 1   result-valid strobe (DONE state)
//   div_hi_o        out 32  remainder
//   div_lo_o        out 32  quotient
import div_seq_pkg::*;

module div_seq (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        div_start_i,
  input  logic        div_signed_i,
  input  logic [31:0] div_src1_i,
  input  logic [31:0] div_src2_i,
  input  logic        div_annul_i,
  output logic        stallreq_div_o,
  output logic        div_busy_o,
  output logic        div_done_o,
  output logic [31:0] div_hi_o,
  output logic [31:0] div_lo_o
);

  div_state_e           state;
  div_state_e           state_next;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 accept;
  logic                 stall;
  logic                 last_iter;

  logic        signed_op;    // effective signedness of the request
  logic        sgn;          // latched signedness
  logic [31:0] rem;          // partial remainder
  logic [31:0] quo;          // dividend on accept, then magnitude, then quotient
  logic [31:0] dvs;          // divisor on accept, then its magnitude
  logic        neg_q;        // quotient must be negated in FIX
  logic        neg_r;        // remainder must be negated in FIX
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef DIV_UNSIGNED_EN
  assign signed_op = div_signed_i;
`else
  logic unused_signed;
  assign unused_signed = div_signed_i;
  assign signed_op     = 1'b1;
`endif

  assign last_iter = (cnt == DIV_CNT_W'(DIV_ITER_NUM - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    accept     = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (div_start_i && !div_annul_i) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = DIV_PREP;
        end
      end
      DIV_PREP: begin
        stall      = 1'b1;
        state_next = div_annul_i ? DIV_IDLE : DIV_ITER;
      end
      DIV_ITER: begin
        stall = 1'b1;
        if (div_annul_i) begin
          state_next = DIV_IDLE;
        end else if (last_iter) begin
          state_next = DIV_FIX;
        end
      end
      DIV_FIX: begin
        stall      = 1'b1;
        state_next = div_annul_i ? DIV_IDLE : DIV_DONE;
      end
      // DONE never re-accepts: the held start belongs to the instruction
      // that is just now leaving EXE.
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  div_step u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvs),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt   <= '0;
      sgn   <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            quo <= div_src1_i;
            dvs <= div_src2_i;
            sgn <= signed_op;
          end
        end
        DIV_PREP: begin
          quo   <= abs32(quo, sgn & quo[31]);
          dvs   <= abs32(dvs, sgn & dvs[31]);
          rem   <= '0;
          cnt   <= '0;
          neg_q <= sgn & (quo[31] ^ dvs[31]);
          neg_r <= sgn & quo[31];
        end
        DIV_ITER: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= cnt + 1'b1;
        end
        DIV_FIX: begin
          // Results only move on the way into DONE; a flush here leaves
          // the previous HI/LO visible.
          if (!div_annul_i) begin
            lo <= abs32(quo, neg_q);
            hi <= abs32(rem, neg_r);
          end
        end
        default: ;
      endcase
    end
  end

  assign stallreq_div_o = stall;
  assign div_busy_o     = (state != DIV_IDLE);
  assign div_done_o     = (state == DIV_DONE);
  assign div_hi_o       = hi;
  assign div_lo_o       = lo;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have port cpu_clk_50M  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port cpu_rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port div_start_i  in  1  EXE-stage request: current instruction is DIV; held high while the pipeline is stalled.
REQ-004 SHALL have port div_signed_i  in  1  1 = signed divide, 0 = unsigned.
REQ-005 SHALL have port div_src1_i  in  32  dividend (rs).
REQ-006 SHALL have port div_src2_i  in  32  divisor (rt).
REQ-007 SHALL have port div_annul_i  in  1  flush from exception/ERET; cancels the operation in progress.
REQ-008 SHALL have port stallreq_div_o  out  1  stall request to the stall-control unit.
REQ-009 SHALL have port div_busy_o  out  1  FSM not in IDLE.
REQ-010 SHALL have port div_done_o  out  1  one-cycle result-valid strobe.
REQ-011 SHALL have port div_hi_o  out  32  remainder, destined for HI.
REQ-012 SHALL have port div_lo_o  out  32  quotient, destined for LO.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, ITER, FIX, DONE.
REQ-014 IDLE->PREP SHALL occur when div_start_i=1 and div_annul_i=0; operands and signed flag SHALL be latched on that edge.
REQ-015 PREP SHALL form absolute values of signed operands (1 cycle); ITER SHALL perform 32 restoring shift-subtract steps, one per cycle, counted by a 5-bit counter; FIX SHALL apply sign correction (1 cycle); DONE SHALL last 1 cycle, then go to IDLE unconditionally.
REQ-016 div_done_o SHALL be 1 only in DONE, i.e. on the 35th cycle after the acceptance edge.
REQ-017 stallreq_div_o SHALL equal (IDLE & div_start_i & ~div_annul_i) | PREP | ITER | FIX; SHALL be 0 in DONE so EXE advances with the result.
REQ-018 DONE->IDLE SHALL NOT re-accept the still-asserted div_start_i in the same edge; a new request is accepted only from IDLE.
REQ-019 Signed rules: quotient negative iff operand signs differ; remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (wrap).
REQ-020 Divisor zero SHALL NOT trap: the unsigned core yields quotient 0xFFFFFFFF, remainder |dividend|, after which REQ-019 sign fixup applies.
REQ-021 div_annul_i=1 in any non-IDLE state SHALL force IDLE on the next edge, with no DONE and div_hi_o/div_lo_o unchanged.
REQ-022 div_hi_o/div_lo_o SHALL be registered, updated only on entry to DONE, and held until the next DONE.

Reset
REQ-023 With cpu_rst_n=0: state=IDLE, counter=0, stallreq_div_o=0, div_busy_o=0, div_done_o=0, div_hi_o=div_lo_o=0, independent of the clock.
REQ-024 Reset asserted mid-ITER SHALL abandon the operation; after release the block is IDLE and accepts a new start.

Configuration
REQ-025 Macro DIV_UNSIGNED_EN: when defined, div_signed_i is honored (DIV and DIVU).
REQ-026 When DIV_UNSIGNED_EN is undefined, div_signed_i SHALL be ignored and every operation is signed.

Structure
REQ-027 State encodings (DIV_IDLE, DIV_PREP, DIV_ITER, DIV_FIX, DIV_DONE) and DIV_ITER_NUM=32 SHALL live in the shared defines.v.
REQ-028 The per-iteration compare/subtract/shift SHALL be a combinational sub-module div_step; div_seq holds the FSM, counter and registers.

Verification
REQ-029 signed 100 / 7: accept at cycle 0 -> stall high cycles 0..34, done at cycle 35, lo=14, hi=2.
REQ-030 signed -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-031 signed 7 / 0 -> lo=0xFFFFFFFF, hi=7, no other side effect.
REQ-032 Annul at ITER count 10 -> IDLE next cycle, no done, stall low, outputs unchanged; next start completes correctly.
REQ-033 Reset pulse mid-ITER -> all outputs 0 immediately; fresh 100 / 7 afterwards gives lo=14, hi=2.
REQ-034 DIV_UNSIGNED_EN defined, unsigned 0xFFFFFFFE / 2 -> lo=0x7FFFFFFF, hi=0; with the macro undefined, the same inputs -> lo=0xFFFFFFFF (signed -2/2), hi=0.
